// File: rtl/ifmap_sched_pkg.sv
// ----------------------------------------------------------------------------
// ifmap_sched_pkg
// Shared definitions for the ifmap pass scheduler and the index generator
// it drives: the scheduler state encoding and the default field widths.
// The width defaults must stay in step with the generator's base ports.
// ----------------------------------------------------------------------------
package ifmap_sched_pkg;

    localparam int N_WIDTH_DEF   = 3;   // generator ifmap_base width
    localparam int C_WIDTH_DEF   = 10;  // generator channel_base width
    localparam int n_WIDTH_DEF   = 3;   // ifmaps per pass
    localparam int q_WIDTH_DEF   = 3;   // generator q
    localparam int r_WIDTH_DEF   = 2;   // generator r
    localparam int P_WIDTH_DEF   = 6;   // pass counters (both loops)
    localparam int CNT_WIDTH_DEF = 24;  // issued-index counter

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/ifmap_pass_scheduler_pass_counter.sv
// ----------------------------------------------------------------------------
// pass_counter
// Wrapping pass index counter used for both the inner (channel) and outer
// (ifmap) loops of the scheduler.
//
// Ports:
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset
//   i_clr    in  synchronous clear to 0 (takes priority over i_inc)
//   i_inc    in  advance; wraps to 0 when the count is already the last pass
//   i_limit  in  number of passes in this loop
//   o_count  out current pass index
//   o_last   out current index is the final pass (i_limit-1)
// ----------------------------------------------------------------------------
module pass_counter
    import ifmap_sched_pkg::*;
#(
    parameter int P_WIDTH = P_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_clr,
    input  logic               i_inc,
    input  logic [P_WIDTH-1:0] i_limit,
    output logic [P_WIDTH-1:0] o_count,
    output logic               o_last
);

    logic [P_WIDTH-1:0] r_count;
    logic               w_last;

    assign w_last = (r_count == (i_limit - P_WIDTH'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_last ? '0 : r_count + P_WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = w_last;

endmodule

// File: rtl/ifmap_pass_scheduler.sv
// ----------------------------------------------------------------------------
// ifmap_pass_scheduler
// Walks the ifmap index generator over a whole layer: outer loop over ifmap
// passes, inner loop over channel passes. Each pass gets a fresh pair of
// bases, a one-cycle gen_start, and runs until the generator's gen_done.
// The downstream FIFO full flag is passed straight through as gen_await.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cfg_valid / cfg_ready        layer configuration handshake (ready in IDLE)
//   cfg_ifmap_passes/chan_passes outer/inner pass counts
//   cfg_n, cfg_q, cfg_r          ifmaps per pass, generator q and r
//   abort                        finish the current pass, then stop
//   fifo_full                    downstream FIFO full (already in clk domain)
//   gen_start/gen_await          generator start pulse and stall
//   gen_busy/gen_done            generator index strobe and done pulse
//   gen_ifmap_base/channel_base  bases for the current pass
//   ifmap_pass/chan_pass         current loop indices
//   sched_busy/done/aborted      status: not idle, completion pulse, sticky abort
//   issued_count                 gen_busy cycles since the last cfg accept
// ----------------------------------------------------------------------------
module ifmap_pass_scheduler
    import ifmap_sched_pkg::*;
#(
    parameter int N_WIDTH   = N_WIDTH_DEF,
    parameter int C_WIDTH   = C_WIDTH_DEF,
    parameter int n_WIDTH   = n_WIDTH_DEF,
    parameter int q_WIDTH   = q_WIDTH_DEF,
    parameter int r_WIDTH   = r_WIDTH_DEF,
    parameter int P_WIDTH   = P_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [P_WIDTH-1:0]   cfg_ifmap_passes,
    input  logic [P_WIDTH-1:0]   cfg_chan_passes,
    input  logic [n_WIDTH-1:0]   cfg_n,
    input  logic [q_WIDTH-1:0]   cfg_q,
    input  logic [r_WIDTH-1:0]   cfg_r,
    input  logic                 abort,
    input  logic                 fifo_full,
    output logic                 gen_start,
    output logic                 gen_await,
    input  logic                 gen_busy,
    input  logic                 gen_done,
    output logic [N_WIDTH-1:0]   gen_ifmap_base,
    output logic [C_WIDTH-1:0]   gen_channel_base,
    output logic [P_WIDTH-1:0]   ifmap_pass,
    output logic [P_WIDTH-1:0]   chan_pass,
    output logic                 sched_busy,
    output logic                 sched_done,
    output logic                 sched_aborted,
    output logic [CNT_WIDTH-1:0] issued_count
);

    localparam int QR_W = q_WIDTH + r_WIDTH;

    sched_state_t r_state, w_next;

    logic [P_WIDTH-1:0]   r_ifmap_passes;
    logic [P_WIDTH-1:0]   r_chan_passes;
    logic [n_WIDTH-1:0]   r_n;
    logic [QR_W-1:0]      r_qr;
    logic [N_WIDTH-1:0]   r_ifmap_base;
    logic [C_WIDTH-1:0]   r_chan_base;
    logic                 r_abort_pend;
    logic                 r_aborted;
    logic [CNT_WIDTH-1:0] r_issued;

    logic w_accept;
    logic w_cfg_zero;
    logic w_chan_last;
    logic w_ifmap_last;
    logic w_final;
    logic w_chan_inc;
    logic w_ifmap_inc;

    assign w_accept   = (r_state == IDLE) && cfg_valid;
    assign w_cfg_zero = (cfg_ifmap_passes == '0) || (cfg_chan_passes == '0);
    assign w_final    = w_chan_last && w_ifmap_last;

    // Loop advance happens only in NEXT and only when the run continues.
    // The inner counter wraps to 0 by itself when it steps past its last pass.
    assign w_chan_inc  = (r_state == NEXT) && !r_abort_pend && !w_final;
    assign w_ifmap_inc = w_chan_inc && w_chan_last;

    pass_counter #(.P_WIDTH(P_WIDTH)) u_chan_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_accept),
        .i_inc   (w_chan_inc),
        .i_limit (r_chan_passes),
        .o_count (chan_pass),
        .o_last  (w_chan_last)
    );

    pass_counter #(.P_WIDTH(P_WIDTH)) u_ifmap_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_accept),
        .i_inc   (w_ifmap_inc),
        .i_limit (r_ifmap_passes),
        .o_count (ifmap_pass),
        .o_last  (w_ifmap_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        cfg_ready  = 1'b0;
        gen_start  = 1'b0;
        sched_busy = 1'b1;
        sched_done = 1'b0;
        case (r_state)
            IDLE: begin
                cfg_ready  = 1'b1;
                sched_busy = 1'b0;
                if (cfg_valid) begin
                    w_next = w_cfg_zero ? DONE : START;
                end
            end
            START: begin
                gen_start = 1'b1;
                w_next    = RUN;
            end
            RUN: begin
                if (gen_done) begin
                    w_next = NEXT;
                end
            end
            NEXT: begin
                if (r_abort_pend || w_final) begin
                    w_next = DONE;
                end else begin
                    w_next = START;
                end
            end
            DONE: begin
                sched_done = 1'b1;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Configuration latch and base accumulators. Bases only move in NEXT,
    // so they hold steady from START through the whole pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ifmap_passes <= '0;
            r_chan_passes  <= '0;
            r_n            <= '0;
            r_qr           <= '0;
            r_ifmap_base   <= '0;
            r_chan_base    <= '0;
            r_aborted      <= 1'b0;
            r_issued       <= '0;
        end else if (w_accept) begin
            r_ifmap_passes <= cfg_ifmap_passes;
            r_chan_passes  <= cfg_chan_passes;
            r_n            <= cfg_n;
            r_qr           <= QR_W'(cfg_q) * QR_W'(cfg_r);
            r_ifmap_base   <= '0;
            r_chan_base    <= '0;
            r_aborted      <= 1'b0;
            r_issued       <= '0;
        end else begin
            if (w_chan_inc) begin
                r_chan_base <= w_chan_last ? '0 : r_chan_base + C_WIDTH'(r_qr);
            end
            if (w_ifmap_inc) begin
                r_ifmap_base <= r_ifmap_base + N_WIDTH'(r_n);
            end
            if ((r_state == NEXT) && r_abort_pend) begin
                r_aborted <= 1'b1;
            end
            if ((r_state != IDLE) && gen_busy && (r_issued != {CNT_WIDTH{1'b1}})) begin
                r_issued <= r_issued + CNT_WIDTH'(1);
            end
        end
    end

    // Abort is only a request to stop at the next pass boundary; a gen_done
    // in the same cycle still completes the pass because NEXT sees the flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_abort_pend <= 1'b0;
        end else if (r_state == DONE) begin
            r_abort_pend <= 1'b0;
        end else if (abort && ((r_state == START) || (r_state == RUN))) begin
            r_abort_pend <= 1'b1;
        end
    end

    // Pure pass-through: any added register here could let the FIFO overflow.
    assign gen_await        = fifo_full;
    assign gen_ifmap_base   = r_ifmap_base;
    assign gen_channel_base = r_chan_base;
    assign sched_aborted    = r_aborted;
    assign issued_count     = r_issued;

endmodule
